kcpsm_test_sequencer: RTL and testbench
=======================================

# kcpsm_test_sequencer

Hardware sequencer for one test run of the `kcpsmx` core. It holds the core in reset, streams a program image into the instruction ROM write port, and releases the core. It then snoops scratchpad writes until the last location (address `SPR_DEPTH-1`) is written, lets the core drain, re-asserts core reset, and streams the full scratchpad contents out over a valid/ready port. It sits between the test/host side and the `kcpsmx`, `rom` and `scratch` instances, replacing bench-side `$readmemh` and scratchpad polling.

## Interface
Parameters:
- `ROM_DEPTH`, 1024, instruction ROM words; address width is `$clog2(ROM_DEPTH)` (AW).
- `INSTR_WIDTH`, 18, instruction word width.
- `SPR_DEPTH`, 64, scratchpad bytes; address width is `$clog2(SPR_DEPTH)` (SW).
- `RST_HOLD`, 4, cycles the core stays in reset after the ROM load completes.
- `DRAIN_CYCLES`, 20, cycles the core keeps running after the last-location write.
- `TIMEOUT_W`, 20, width of the run-cycle counter.

Ports:
- `clk`  in  1  clock; all logic is on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- `prog_last`  in  AW  index of the last program word; sampled on `start`.
- `ld_valid`  in  1  program word valid.
- `ld_ready`  out  1  program word accepted this cycle when high together with `ld_valid`.
- `ld_data`  in  INSTR_WIDTH  program word.
- `rom_we`  out  1  ROM write enable, equal to `ld_valid & ld_ready` (combinational).
- `rom_addr`  out  AW  ROM write address, driven from the load counter.
- `rom_wdata`  out  INSTR_WIDTH  equal to `ld_data`.
- `cpu_reset`  out  1  active-high reset to `kcpsmx`; registered.
- `spr_we`  in  1  scratchpad write strobe, snooped.
- `spr_waddr`  in  SW  scratchpad write address, snooped.
- `spr_raddr`  out  SW  scratchpad read address.
- `spr_rdata`  in  8  scratchpad read data, valid one cycle after `spr_raddr`.
- `dump_valid`  out  1  dump beat valid.
- `dump_ready`  in  1  dump beat accepted.
- `dump_addr`  out  SW  scratchpad address of the current beat.
- `dump_data`  out  8  scratchpad byte of the current beat.
- `busy`  out  1  high in every state other than IDLE and DONE.
- `done`  out  1  high in DONE.
- `timeout`  out  1  sticky flag: the run ended by watchdog.
- `run_cycles`  out  TIMEOUT_W  number of RUN cycles; saturates at all-ones.

## Operation
States: IDLE, LOAD, HOLD, RUN, DRAIN, DUMP, DONE.
- **IDLE**
  - `cpu_reset`=1.
  - `start` → LOAD. On entry: load counter=0; `timeout` and `run_cycles` are cleared.
- **LOAD**
  - `ld_ready`=1.
  - Each handshake writes `ld_data` to `rom_addr` and increments the counter.
  - Handshake at counter == `prog_last` → HOLD.
  - Gaps in `ld_valid` stall the load with no writes.
- **HOLD**
  - Counts `RST_HOLD` cycles with `cpu_reset`=1, then → RUN.
- **RUN**
  - `cpu_reset`=0.
  - `run_cycles` increments each cycle.
  - `spr_we` with `spr_waddr == SPR_DEPTH-1` → DRAIN. That cycle counts in `run_cycles`.
  - Writes to any other address are ignored.
- **DRAIN**
  - `DRAIN_CYCLES` cycles with `cpu_reset`=0 and `run_cycles` frozen, then → DUMP.
  - `cpu_reset`=1 from the first DUMP cycle.
- **DUMP**, for each address i = 0 … `SPR_DEPTH-1`:
  - Drive `spr_raddr`=i, capture `spr_rdata` into `dump_data` on the next cycle, then assert `dump_valid` with `dump_addr`=i.
  - `dump_data`/`dump_addr` stay stable while `dump_valid & ~dump_ready`.
  - Handshake on i = `SPR_DEPTH-1` → DONE.
- **DONE**
  - `done`=1, `cpu_reset`=1.
  - `run_cycles` and `timeout` are held.
  - `start` → LOAD with the same entry actions as from IDLE.
- `start` in any busy state is ignored.
- Async reset in any state: immediate return to IDLE with all outputs at their reset values.
- `ld_valid` outside LOAD is ignored: `ld_ready`=0 and no ROM write.

## Timing
- Reset values:
  - `cpu_reset`=1, asserted asynchronously.
  - All other outputs 0. `rom_wdata` follows `ld_data` combinationally and has no register reset.
- `start` → LOAD in the next cycle; `ld_ready` rises one cycle after `start`.
- Last load handshake at cycle t:
  - HOLD spans t+1 … t+`RST_HOLD`.
  - `cpu_reset` falls at t+`RST_HOLD`+1.
- Last-location write at cycle r:
  - DRAIN spans r+1 … r+`DRAIN_CYCLES`.
  - `cpu_reset` rises and DUMP starts at r+`DRAIN_CYCLES`+1.
- DUMP pacing:
  - Entry cycle d drives `spr_raddr`=0; `dump_valid` is first high at d+2.
  - Address i+1 is driven in the cycle after the beat-i handshake, so the peak rate is one beat every 3 cycles.
- `done` rises the cycle after the final dump handshake.

## Configuration
- `KCPSM_SEQ_TIMEOUT_EN` defined:
  - When `run_cycles` reaches all-ones while in RUN, `timeout` is set and the state moves directly to DUMP (DRAIN is skipped).
  - The partial scratchpad is dumped and the run ends in DONE.
- Not defined:
  - `timeout` is tied to 0.
  - RUN waits indefinitely for the last-location write; `run_cycles` still saturates.

## Test plan
- Assert `reset` low mid-cycle → `cpu_reset`=1 immediately. After release: `busy`/`done`/`dump_valid`/`ld_ready`=0 and `run_cycles`=0.
- `start` with `prog_last`=2, then words 0x00001, 0x3ABCD, 0x2FFFF with a 2-cycle `ld_valid` gap → `rom_we` at addresses 0, 1, 2 only. `cpu_reset` stays high 4 more cycles, then falls.
- In RUN: `spr_we` at `spr_waddr`=62 (no effect), then at 63 on the 100th RUN cycle → `run_cycles`=100. `cpu_reset` rises exactly 21 cycles later.
- Scratchpad preloaded with spr[i]=i^0xA5 and `dump_ready` toggled 1010… → 64 beats, `dump_addr` 0…63 in order, `dump_data`=i^0xA5, data stable during stalls. `done`=1 after beat 63.
- `TIMEOUT_W`=8 with no write to address 63:
  - Macro defined → `timeout`=1 after 255 RUN cycles, 64 beats are dumped, `done`=1.
  - Macro undefined → the core stays in RUN and `run_cycles`=255.
- `start` pulsed during RUN is ignored. Async reset asserted during DUMP beat 10 → IDLE, `dump_valid`=0 at once. A new `start` then runs a clean load.

Source files
------------

// File: rtl/kcpsm_test_sequencer.sv
// Test-run sequencer for kcpsmx: ROM load, reset release, scratchpad snoop, drain, scratchpad dump.
// Define KCPSM_SEQ_TIMEOUT_EN to end a run by watchdog when run_cycles saturates.
module kcpsm_test_sequencer #(
    parameter int ROM_DEPTH    = 1024,
    parameter int INSTR_WIDTH  = 18,
    parameter int SPR_DEPTH    = 64,
    parameter int RST_HOLD     = 4,
    parameter int DRAIN_CYCLES = 20,
    parameter int TIMEOUT_W    = 20,
    localparam int AW = $clog2(ROM_DEPTH),
    localparam int SW = $clog2(SPR_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [AW-1:0]          prog_last,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [INSTR_WIDTH-1:0] ld_data,
    output logic                   rom_we,
    output logic [AW-1:0]          rom_addr,
    output logic [INSTR_WIDTH-1:0] rom_wdata,
    output logic                   cpu_reset,
    input  logic                   spr_we,
    input  logic [SW-1:0]          spr_waddr,
    output logic [SW-1:0]          spr_raddr,
    input  logic [7:0]             spr_rdata,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [SW-1:0]          dump_addr,
    output logic [7:0]             dump_data,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [TIMEOUT_W-1:0]   run_cycles,
    output logic [2:0]             dbg_state
);

    localparam int CMAX = (RST_HOLD > DRAIN_CYCLES) ? RST_HOLD : DRAIN_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DRAIN, S_DUMP, S_DONE
    } state_e;

    typedef enum logic [1:0] {PH_ADDR, PH_CAP, PH_VALID} dump_ph_e;

    state_e                 state_q, state_d;
    dump_ph_e               dump_ph_q, dump_ph_d;
    logic [AW-1:0]          ld_cnt_q, ld_cnt_d;
    logic [AW-1:0]          prog_last_q, prog_last_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0]   run_cycles_q, run_cycles_d, run_inc;
    logic                   timeout_q, timeout_d;
    logic [SW-1:0]          dump_idx_q, dump_idx_d;
    logic                   dump_valid_q, dump_valid_d;
    logic [7:0]             dump_data_q, dump_data_d;
    logic                   cpu_reset_q, cpu_reset_d;

    // Both ports are valid/ready: a beat transfers on a cycle where valid and ready are both high;
    // the sender holds its payload stable while valid is high and ready is low.
    assign ld_ready   = (state_q == S_LOAD);
    assign rom_we     = ld_valid & ld_ready;
    assign rom_addr   = ld_cnt_q;
    assign rom_wdata  = ld_data;
    assign cpu_reset  = cpu_reset_q;
    assign spr_raddr  = dump_idx_q;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign timeout    = timeout_q;
    assign run_cycles = run_cycles_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d      = state_q;
        dump_ph_d    = dump_ph_q;
        ld_cnt_d     = ld_cnt_q;
        prog_last_d  = prog_last_q;
        cnt_d        = cnt_q;
        run_cycles_d = run_cycles_q;
        timeout_d    = timeout_q;
        dump_idx_d   = dump_idx_q;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;
        run_inc      = (&run_cycles_q) ? run_cycles_q : run_cycles_q + 1'b1;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    ld_cnt_d     = '0;
                    prog_last_d  = prog_last;
                    run_cycles_d = '0;
                    timeout_d    = 1'b0;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    if (ld_cnt_q == prog_last_q) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(RST_HOLD - 1)) state_d = S_RUN;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            S_RUN: begin
                run_cycles_d = run_inc;
                if (spr_we && (spr_waddr == SW'(SPR_DEPTH - 1))) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
`ifdef KCPSM_SEQ_TIMEOUT_EN
                else if (&run_inc) begin
                    timeout_d  = 1'b1;
                    state_d    = S_DUMP;
                    dump_idx_d = '0;
                    dump_ph_d  = PH_ADDR;
                end
`endif
            end
            S_DRAIN: begin
                if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                    state_d    = S_DUMP;
                    dump_idx_d = '0;
                    dump_ph_d  = PH_ADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DUMP: begin
                // Read address is driven one cycle, data captured the next, beat offered after that.
                unique case (dump_ph_q)
                    PH_ADDR: dump_ph_d = PH_CAP;
                    PH_CAP: begin
                        dump_data_d  = spr_rdata;
                        dump_valid_d = 1'b1;
                        dump_ph_d    = PH_VALID;
                    end
                    PH_VALID: begin
                        if (dump_ready) begin
                            dump_valid_d = 1'b0;
                            if (dump_idx_q == SW'(SPR_DEPTH - 1)) begin
                                state_d = S_DONE;
                            end else begin
                                dump_idx_d = dump_idx_q + 1'b1;
                                dump_ph_d  = PH_ADDR;
                            end
                        end
                    end
                    default: dump_ph_d = PH_ADDR;
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        cpu_reset_d = !((state_d == S_RUN) || (state_d == S_DRAIN));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            dump_ph_q    <= PH_ADDR;
            ld_cnt_q     <= '0;
            prog_last_q  <= '0;
            cnt_q        <= '0;
            run_cycles_q <= '0;
            timeout_q    <= 1'b0;
            dump_idx_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            dump_ph_q    <= dump_ph_d;
            ld_cnt_q     <= ld_cnt_d;
            prog_last_q  <= prog_last_d;
            cnt_q        <= cnt_d;
            run_cycles_q <= run_cycles_d;
            timeout_q    <= timeout_d;
            dump_idx_q   <= dump_idx_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

endmodule

// File: tb/tb_kcpsm_test_sequencer.sv
// Directed bench for kcpsm_test_sequencer (TIMEOUT_W=8); expectations follow KCPSM_SEQ_TIMEOUT_EN.
module tb_kcpsm_test_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_HOLD = 3'd2, ST_RUN = 3'd3,
                           ST_DRAIN = 3'd4, ST_DUMP = 3'd5, ST_DONE = 3'd6;

    logic        clk = 1'b0;
    logic        reset, start, ld_valid, spr_we, dump_ready;
    logic [9:0]  prog_last;
    logic [17:0] ld_data;
    logic [5:0]  spr_waddr;
    logic [7:0]  spr_rdata = 8'h00;
    logic        ld_ready, rom_we, cpu_reset, dump_valid, busy, done, timeout;
    logic [9:0]  rom_addr;
    logic [17:0] rom_wdata;
    logic [5:0]  spr_raddr, dump_addr;
    logic [7:0]  dump_data;
    logic [7:0]  run_cycles;
    logic [2:0]  dbg_state;

    kcpsm_test_sequencer #(.TIMEOUT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_last(prog_last),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .spr_we(spr_we), .spr_waddr(spr_waddr),
        .spr_raddr(spr_raddr), .spr_rdata(spr_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .busy(busy), .done(done), .timeout(timeout),
        .run_cycles(run_cycles), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // scoreboard state
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_beats = 0;
    logic [15:0] exp_q[$];
    logic [9:0]  rom_a[$];
    logic [17:0] rom_d[$];
    logic [7:0]  spr_mem [64];
    logic [7:0]  held_data;
    logic [5:0]  held_addr;
    bit          held_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) spr_rdata <= spr_mem[spr_raddr];

    always @(posedge clk) begin
        if (reset && rom_we) begin
            rom_a.push_back(rom_addr);
            rom_d.push_back(rom_wdata);
        end
    end

    always @(posedge clk) begin
        logic [15:0] e;
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_data", dump_data, held_data);
                check("stall_addr", dump_addr, held_addr);
            end
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    check("dump_extra", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("dump_addr", dump_addr, e[13:8]);
                    check("dump_data", dump_data, e[7:0]);
                end
                n_beats++;
            end
            held_v    = dump_valid && !dump_ready;
            held_data = dump_data;
            held_addr = dump_addr;
        end
    end

    task automatic fill_exp(input int n);
        exp_q.delete();
        n_beats = 0;
        for (int i = 0; i < n; i++) exp_q.push_back({2'b00, 6'(i), 8'(i) ^ 8'hA5});
    endtask

    // Called at a negedge; returns at the negedge right after the last load handshake.
    task automatic load_words(input int last);
        start = 1'b1;
        prog_last = 10'(last);
        @(negedge clk);
        start = 1'b0;
        check("start_ld_ready", ld_ready, 1);
        check("start_clr_run", run_cycles, 0);
        check("start_clr_timeout", timeout, 0);
        for (int i = 0; i <= last; i++) begin
            ld_valid = 1'b1;
            ld_data  = 18'h100 + 18'(i);
            @(negedge clk);
        end
        ld_valid = 1'b0;
    endtask

    task automatic dump_until_done(input bit toggle);
        int c = 0;
        while (!done && c < 2000) begin
            dump_ready = toggle ? ~dump_ready : 1'b1;
            @(negedge clk);
            c++;
        end
        dump_ready = 1'b0;
        check("done_set", done, 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; prog_last = '0; ld_valid = 1'b0; ld_data = '0;
        spr_we = 1'b0; spr_waddr = '0; dump_ready = 1'b0;
        for (int i = 0; i < 64; i++) spr_mem[i] = 8'(i) ^ 8'hA5;

        repeat (3) @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_dump_valid", dump_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_ld_ready", ld_ready, 0);
        check("idle_run_cycles", run_cycles, 0);
        check("idle_cpu_reset", cpu_reset, 1);
        check("idle_state", dbg_state, ST_IDLE);

        // run 1: three words with a two-cycle gap
        start = 1'b1; prog_last = 10'd2;
        @(negedge clk);
        start = 1'b0;
        check("load_ready", ld_ready, 1);
        check("load_state", dbg_state, ST_LOAD);
        ld_valid = 1'b1; ld_data = 18'h00001;
        @(negedge clk);
        ld_data = 18'h3ABCD;
        @(negedge clk);
        ld_valid = 1'b0; ld_data = 18'h15555;
        repeat (2) @(negedge clk);
        check("load_gap_ready", ld_ready, 1);
        ld_valid = 1'b1; ld_data = 18'h2FFFF;
        @(negedge clk);
        ld_valid = 1'b0;
        check("hold_state", dbg_state, ST_HOLD);
        check("hold_ld_ready", ld_ready, 0);
        repeat (3) @(negedge clk);
        check("hold_last_cpu_reset", cpu_reset, 1);
        @(negedge clk);
        check("run_cpu_reset", cpu_reset, 0);
        check("run_state", dbg_state, ST_RUN);

        for (int k = 1; k <= 100; k++) begin
            spr_we    = (k == 10) || (k == 100);
            spr_waddr = (k == 100) ? 6'd63 : 6'd62;
            start     = (k == 50);
            ld_valid  = (k == 30);
            ld_data   = 18'h3FFFF;
            if (k == 30) check("run_ld_ready", ld_ready, 0);
            if (k == 51) check("start_ignored", dbg_state, ST_RUN);
            @(negedge clk);
        end
        spr_we = 1'b0; start = 1'b0; ld_valid = 1'b0;
        check("run_cycles_100", run_cycles, 100);
        check("drain_state", dbg_state, ST_DRAIN);
        check("rom_count", rom_a.size(), 3);
        if (rom_a.size() == 3) begin
            check("rom_a0", rom_a[0], 0);
            check("rom_d0", rom_d[0], 18'h00001);
            check("rom_a1", rom_a[1], 1);
            check("rom_d1", rom_d[1], 18'h3ABCD);
            check("rom_a2", rom_a[2], 2);
            check("rom_d2", rom_d[2], 18'h2FFFF);
        end
        repeat (19) @(negedge clk);
        check("drain_end_cpu_reset", cpu_reset, 0);
        @(negedge clk);
        check("dump_cpu_reset", cpu_reset, 1);
        check("dump_run_frozen", run_cycles, 100);
        check("dump_state", dbg_state, ST_DUMP);
        check("dump_raddr0", spr_raddr, 0);
        check("dump_valid_d0", dump_valid, 0);
        fill_exp(64);
        dump_ready = 1'b1;
        @(negedge clk);
        check("dump_valid_d1", dump_valid, 0);
        dump_ready = 1'b0;
        @(negedge clk);
        check("dump_valid_d2", dump_valid, 1);
        check("dump_first_addr", dump_addr, 0);
        check("dump_first_data", dump_data, 8'hA5);
        dump_until_done(1'b1);
        check("run1_beats", n_beats, 64);
        check("run1_exp_left", exp_q.size(), 0);
        check("done_busy", busy, 0);
        check("done_run_held", run_cycles, 100);

        // run 2: async reset during beat 10
        load_words(0);
        repeat (4) @(negedge clk);
        spr_we = 1'b1; spr_waddr = 6'd63;
        @(negedge clk);
        spr_we = 1'b0;
        check("run2_cycles", run_cycles, 1);
        repeat (20) @(negedge clk);
        fill_exp(10);
        dump_ready = 1'b1;
        for (int c = 0; c < 400 && !(dump_valid && dump_addr == 6'd10); c++) @(negedge clk);
        check("beat10_valid", dump_valid, 1);
        check("beat10_addr", dump_addr, 10);
        #2 reset = 1'b0;
        #1;
        check("rst_dump_valid_now", dump_valid, 0);
        check("rst_dump_busy_now", busy, 0);
        check("rst_dump_state", dbg_state, ST_IDLE);
        check("run2_beats", n_beats, 10);
        dump_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // run 3: clean load, then no last-location write
        rom_a.delete(); rom_d.delete();
        load_words(1);
        check("run3_rom_count", rom_a.size(), 2);
        if (rom_a.size() == 2) begin
            check("run3_rom_a0", rom_a[0], 0);
            check("run3_rom_a1", rom_a[1], 1);
            check("run3_rom_d1", rom_d[1], 18'h101);
        end
        repeat (4) @(negedge clk);
        repeat (255) @(negedge clk);
        check("run3_cycles_255", run_cycles, 255);
`ifdef KCPSM_SEQ_TIMEOUT_EN
        check("timeout_set", timeout, 1);
        check("timeout_dump_state", dbg_state, ST_DUMP);
        fill_exp(64);
        dump_until_done(1'b0);
        check("timeout_beats", n_beats, 64);
        check("timeout_held", timeout, 1);
        load_words(0);
        repeat (4) @(negedge clk);
`else
        check("no_timeout", timeout, 0);
        check("wait_state", dbg_state, ST_RUN);
        repeat (20) @(negedge clk);
        check("run_saturated", run_cycles, 255);
        check("still_run", dbg_state, ST_RUN);
`endif
        check("pre_async_cpu_reset", cpu_reset, 0);
        #2 reset = 1'b0;
        #1;
        check("async_cpu_reset", cpu_reset, 1);
        check("async_busy", busy, 0);
        check("async_run_cycles", run_cycles, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got no end of test, expected finish before 500000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
